// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: state codes, opcodes,
// datapath mux/ALU encodings and widths.
package mc_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned WAIT_W   = 8;   // holds MAX_WAIT up to 255
  localparam int unsigned CNT_W    = 32;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_BNE    = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that stall on memory and are therefore subject to the wait timer.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Consecutive not-ready counter with timeout compare.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   waiting      : FSM is in a memory-stall state
//   mem_ready    : memory access completes this cycle
//   timeout_c    : combinational, count reached MAX_WAIT while still not ready
module mc_wait_timer
  import mc_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout_c
);

  logic [WAIT_W-1:0] count;

  assign timeout_c = waiting && !mem_ready && (count == WAIT_W'(MAX_WAIT));

  // Count only while stalled; any completion, timeout or leaving the wait
  // states returns the counter to zero, so entering a new wait state starts fresh.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (waiting && !mem_ready && !timeout_c) begin
      count <= count + WAIT_W'(1);
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM (Moore decode, FETCH strobes follow mem_ready).
// Optional macro MC_PERF_CNT_EN adds cycle_cnt / instr_cnt performance counters.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   opcode, mem_ready   : IR[31:26] and memory completion
//   pc_write*, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
//   reg_write, alu_src_a, alu_src_b, alu_op, pc_source : datapath controls
//   state               : current state code
//   illegal_op          : pulse in DECODE on an unsupported opcode
//   mem_timeout         : pulse when a memory wait exceeds MAX_WAIT
//   cycle_cnt, instr_cnt: performance counters (MC_PERF_CNT_EN only)
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                pc_write_cond_ne,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic [STATE_W-1:0]  state,
  output logic                illegal_op,
  output logic                mem_timeout
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instr_cnt
`endif
);

  state_t state_q;
  state_t state_d;
  logic   timeout_c;

  mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clock     (clock),
    .reset     (reset),
    .waiting   (is_wait_state(state_q)),
    .mem_ready (mem_ready),
    .timeout_c (timeout_c)
  );

  assign state = state_q;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d          = state_q;
    pc_write         = 1'b0;
    pc_write_cond    = 1'b0;
    pc_write_cond_ne = 1'b0;
    iord             = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    ir_write         = 1'b0;
    mem_to_reg       = 1'b0;
    reg_dst          = 1'b0;
    reg_write        = 1'b0;
    alu_src_a        = 1'b0;
    alu_src_b        = SRCB_B;
    alu_op           = ALU_ADD;
    pc_source        = PCSRC_ALU;
    illegal_op       = 1'b0;
    mem_timeout      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        // A timeout here simply re-enters FETCH.
        if (mem_ready) state_d = S_DECODE;
        else if (timeout_c) state_d = S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ;
          OP_BNE:       state_d = S_BNE;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
        else if (timeout_c) state_d = S_FETCH;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready || timeout_c) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_source     = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
        state_d       = S_FETCH;
      end
      S_BNE: begin
        alu_src_a        = 1'b1;
        alu_op           = ALU_SUB;
        pc_source        = PCSRC_ALUOUT;
        pc_write_cond_ne = 1'b1;
        state_d          = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    mem_timeout = timeout_c;

    // Reset abandons the instruction: suppress every architectural write and
    // both pulses in the cycle reset is sampled.
    if (reset) begin
      pc_write         = 1'b0;
      pc_write_cond    = 1'b0;
      pc_write_cond_ne = 1'b0;
      mem_write        = 1'b0;
      ir_write         = 1'b0;
      reg_write        = 1'b0;
      illegal_op       = 1'b0;
      mem_timeout      = 1'b0;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic instr_done_c;

  // An instruction retires when a final state hands control back to FETCH.
  always_comb begin
    instr_done_c = 1'b0;
    if (state_d == S_FETCH) begin
      case (state_q)
        S_MEMWB, S_MEMWR, S_ALUWB, S_BEQ, S_BNE, S_JUMP, S_ADDIWB: instr_done_c = 1'b1;
        default: instr_done_c = 1'b0;
      endcase
    end
  end

  // Free-running performance counters, wrapping naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (instr_done_c) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-level reference
// model compared every cycle, plus directed literal expectations.
module tb_multicycle_control;

  localparam int MW = 3;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_BNE  = 6'b000101;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_BAD  = 6'b111111;

  // Write strobes in the packed control word: pc_write, cond, cond_ne, mem_write, ir_write, reg_write.
  localparam logic [16:0] WR_MASK = 17'b1_1100_1100_1000_0000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'b0;
  logic       mem_ready = 1'b0;

  logic       pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       illegal_op, mem_timeout;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  logic [16:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  multicycle_control #(.MAX_WAIT(MW)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_write_cond_ne(pc_write_cond_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
`ifdef MC_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  function automatic bit legal(input logic [5:0] op);
    return op inside {T_R, T_LW, T_SW, T_BEQ, T_BNE, T_J, T_ADDI};
  endfunction

  function automatic int path_len(input logic [5:0] op);
    case (op)
      T_LW:               return 5;
      T_R, T_SW, T_ADDI:  return 4;
      T_BEQ, T_BNE, T_J:  return 3;
      default:            return 2;
    endcase
  endfunction

  // State code visited at step 'pos' of an instruction.
  function automatic int state_at(input logic [5:0] op, input int pos);
    if (pos == 0) return 0;
    if (pos == 1) return 1;
    case (op)
      T_LW:   return (pos == 2) ? 2 : (pos == 3) ? 3 : 4;
      T_SW:   return (pos == 2) ? 2 : 5;
      T_R:    return (pos == 2) ? 6 : 7;
      T_ADDI: return (pos == 2) ? 11 : 12;
      T_BEQ:  return 8;
      T_BNE:  return 9;
      T_J:    return 10;
      default: return 0;
    endcase
  endfunction

  function automatic bit waitable(input int code);
    return (code == 0) || (code == 3) || (code == 5);
  endfunction

  // Control word per state, bit order matches 'ctrl'.
  function automatic logic [16:0] ctrl_of(input int code);
    logic [16:0] c;
    c = '0;
    case (code)
      0:  begin c[12] = 1'b1; c[5:4] = 2'b01; end
      1:  c[5:4] = 2'b11;
      2, 11: begin c[6] = 1'b1; c[5:4] = 2'b10; end
      3:  begin c[13] = 1'b1; c[12] = 1'b1; end
      4:  begin c[9] = 1'b1; c[7] = 1'b1; end
      5:  begin c[13] = 1'b1; c[11] = 1'b1; end
      6:  begin c[6] = 1'b1; c[3:2] = 2'b10; end
      7:  begin c[8] = 1'b1; c[7] = 1'b1; end
      8:  begin c[6] = 1'b1; c[3:2] = 2'b01; c[1:0] = 2'b01; c[15] = 1'b1; end
      9:  begin c[6] = 1'b1; c[3:2] = 2'b01; c[1:0] = 2'b01; c[14] = 1'b1; end
      10: begin c[16] = 1'b1; c[1:0] = 2'b10; end
      12: c[7] = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  int m_pos = 0;
  int m_wait = 0;
  bit m_live = 1'b0;

  always @(posedge clock) begin
    int cur;
    if (reset) begin
      m_pos  <= 0;
      m_wait <= 0;
      m_live <= 1'b1;
    end else if (m_live) begin
      cur = state_at(opcode, m_pos);
      if (waitable(cur) && !mem_ready) begin
        if (m_wait == MW) begin
          m_pos  <= 0;
          m_wait <= 0;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else begin
        m_wait <= 0;
        m_pos  <= (m_pos + 1 >= path_len(opcode)) ? 0 : m_pos + 1;
      end
    end
  end

  always @(negedge clock) begin
    int code;
    logic [16:0] e;
    if (m_live) begin
      code = state_at(opcode, m_pos);
      e = ctrl_of(code);
      if (code == 0) begin
        e[16] = mem_ready;
        e[10] = mem_ready;
      end
      if (reset) e = e & ~WR_MASK;
      chk("model_state", int'(state), code);
      chk("model_ctrl", int'(ctrl), int'(e));
      chk("model_illegal", int'(illegal_op), int'(!reset && m_pos == 1 && !legal(opcode)));
      chk("model_timeout", int'(mem_timeout),
          int'(!reset && waitable(code) && !mem_ready && m_wait == MW));
    end
  end

  // ---------------- directed stimulus with literal checks ----------------
  int          s_state;
  logic [16:0] s_ctrl;
  int          s_ill, s_to;
  int          pulses;

  task automatic step(input logic [5:0] op, input logic rdy);
    opcode    = op;
    mem_ready = rdy;
    #1;
    s_state = int'(state);
    s_ctrl  = ctrl;
    s_ill   = int'(illegal_op);
    s_to    = int'(mem_timeout);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) step(T_R, 1'b1);
    reset = 1'b0;

    // lw, zero waits: 0,1,2,3,4 with reg_write only in MEMWB
    for (int i = 0; i < 5; i++) begin
      step(T_LW, 1'b1);
      if (i == 0) begin
        chk("reset_fetch_state", s_state, 0);
        chk("reset_fetch_mem_read", int'(s_ctrl[12]), 1);
        chk("reset_fetch_illegal", s_ill, 0);
      end
      chk("lw_state", s_state, i);
      chk("lw_reg_write", int'(s_ctrl[7]), int'(i == 4));
    end

    // R-type with two FETCH wait cycles
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(T_R, (i >= 2));
      chk("rtype_state", s_state, (i < 3) ? 0 : (i == 3) ? 1 : (i == 4) ? 6 : 7);
      chk("rtype_ir_write", int'(s_ctrl[10]), int'(i == 2));
      pulses += int'(s_ctrl[10]);
    end
    chk("rtype_ir_pulses", pulses, 1);

    // beq then bne back-to-back
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        step((k == 0) ? T_BEQ : T_BNE, 1'b1);
        chk("branch_state", s_state, (i == 2) ? 8 + k : i);
      end
      chk("branch_cond", int'(s_ctrl[15]), int'(k == 0));
      chk("branch_cond_ne", int'(s_ctrl[14]), int'(k == 1));
      chk("branch_pc_source", int'(s_ctrl[1:0]), 1);
    end

    // illegal opcode
    step(T_BAD, 1'b1);
    step(T_BAD, 1'b1);
    chk("illegal_state", s_state, 1);
    chk("illegal_pulse", s_ill, 1);
    chk("illegal_no_write", int'(s_ctrl & WR_MASK), 0);

    // jump follows directly, confirming the return to FETCH
    for (int i = 0; i < 3; i++) step(T_J, 1'b1);
    chk("jump_state", s_state, 10);
    chk("jump_pc_write", int'(s_ctrl[16]), 1);

    // addi
    for (int i = 0; i < 4; i++) begin
      step(T_ADDI, 1'b1);
      chk("addi_state", s_state, (i < 2) ? i : 9 + i);
    end

    // sw, MEMWR timeout in the 4th wait cycle
    step(T_SW, 1'b1);
    step(T_SW, 1'b0);
    step(T_SW, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(T_SW, 1'b0);
      chk("sw_to_state", s_state, 5);
      chk("sw_to_pulse", s_to, int'(i == 3));
    end
    // sw, memory ready in that same cycle wins
    step(T_SW, 1'b1);
    chk("sw_after_to_fetch", s_state, 0);
    step(T_SW, 1'b0);
    step(T_SW, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(T_SW, (i == 3));
      chk("sw_ready_state", s_state, 5);
      chk("sw_ready_no_pulse", s_to, 0);
    end

    // FETCH timeout re-enters FETCH, then R-type completes
    for (int i = 0; i < 5; i++) begin
      step(T_R, 1'b0);
      chk("fetch_to_state", s_state, 0);
      chk("fetch_to_pulse", s_to, int'(i == 3));
    end
    step(T_R, 1'b1);
    step(T_R, 1'b1);
    chk("fetch_to_decode", s_state, 1);
    step(T_R, 1'b1);
    step(T_R, 1'b1);

    // lw, MEMRD timeout
    for (int i = 0; i < 3; i++) step(T_LW, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(T_LW, 1'b0);
      chk("lw_to_pulse", s_to, int'(i == 3));
    end
    step(T_LW, 1'b1);
    chk("lw_to_fetch", s_state, 0);

    // reset during MEMWB abandons the register write
    for (int i = 0; i < 3; i++) step(T_LW, 1'b1);
    reset = 1'b1;
    step(T_LW, 1'b1);
    chk("rst_mid_state", s_state, 4);
    chk("rst_mid_no_write", int'(s_ctrl & WR_MASK), 0);
    reset = 1'b0;
    step(T_LW, 1'b1);
    chk("rst_mid_fetch", s_state, 0);

`ifdef MC_PERF_CNT_EN
    reset = 1'b1;
    step(T_ADDI, 1'b1);
    reset = 1'b0;
    repeat (40) step(T_ADDI, 1'b1);
    chk("perf_cycle_cnt", int'(cycle_cnt), 40);
    chk("perf_instr_cnt", int'(instr_cnt), 10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter: MAX_WAIT, 15, consecutive not-ready cycles tolerated in a memory state before timeout (1..255).
REQ-002 SHALL have these ports, clock and reset first:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26] from the instruction register.
- mem_ready  in  1  memory access completes this cycle.
- pc_write, pc_write_cond, pc_write_cond_ne  out  1 each  PC update enables: unconditional, on Zero, on !Zero.
- iord  out  1  memory address select, 0 = PC, 1 = ALUOut.
- mem_read, mem_write, ir_write  out  1 each  memory and IR strobes.
- mem_to_reg, reg_dst, reg_write  out  1 each  register-file write controls.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump address.
- state  out  4  current FSM state code.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- mem_timeout  out  1  one-cycle pulse on a wait timeout.

Function
REQ-003 SHALL use these state codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BEQ 8, BNE 9, JUMP 10, ADDIEX 11, ADDIWB 12; codes 13-15 SHALL go to FETCH.
REQ-004 SHALL decode all outputs combinationally from the state register (Moore), except ir_write and pc_write in FETCH, which SHALL equal mem_ready; any output not listed for a state SHALL be 0.
REQ-005 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; stay until mem_ready=1, then go to DECODE.
REQ-006 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
REQ-006a DECODE dispatch by opcode:
- 000000 -> EXEC
- 100011 or 101011 -> MEMADR
- 000100 -> BEQ
- 000101 -> BNE
- 000010 -> JUMP
- 001000 -> ADDIEX
- any other -> FETCH, with illegal_op=1 in that DECODE cycle.
REQ-007 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; go to MEMRD if opcode=100011, else to MEMWR.
REQ-008 MEMRD: mem_read=1, iord=1; go to MEMWB on mem_ready.
REQ-008a MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; then FETCH.
REQ-009 MEMWR: mem_write=1, iord=1; go to FETCH on mem_ready.
REQ-010 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then ALUWB.
REQ-010a ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1; then FETCH.
REQ-011 BEQ/BNE: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, and pc_write_cond (BEQ) or pc_write_cond_ne (BNE) =1; then FETCH.
REQ-012 JUMP: pc_write=1, pc_source=10; then FETCH.
REQ-012a ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; then ADDIWB.
REQ-012b ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1; then FETCH.
REQ-013 With zero wait cycles, instruction latency SHALL be: lw 5, R-type/sw/addi 4, beq/bne/j 3 cycles.
REQ-014 Wait counter:
- counts consecutive cycles in FETCH/MEMRD/MEMWR with mem_ready=0;
- clears on any state change or on mem_ready=1.
REQ-014a Timeout: when the count equals MAX_WAIT and mem_ready=0, SHALL pulse mem_timeout for one cycle, go to FETCH, and clear the counter; a timeout in FETCH SHALL re-enter FETCH.
REQ-015 mem_ready=1 in the timeout cycle SHALL take priority: normal transition, no timeout pulse.

Reset
REQ-016 reset SHALL take priority over all inputs and set: state=FETCH, wait counter=0, illegal_op=0, mem_timeout=0.
REQ-017 In the first cycle after reset, outputs SHALL be the FETCH values; asserting reset mid-instruction SHALL abandon the instruction without any further reg_write, mem_write or pc_write.

Configuration
REQ-018 With macro MC_PERF_CNT_EN defined, two extra 32-bit outputs SHALL exist:
- cycle_cnt: +1 every non-reset cycle.
- instr_cnt: +1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BEQ, BNE, JUMP or ADDIWB.
Both SHALL clear on reset and wrap modulo 2^32.
REQ-019 Without MC_PERF_CNT_EN, the ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-020 Shared package mc_pkg SHALL hold: the state typedef/codes, opcode constants, and the alu_op, alu_src_b and pc_source encodings.
REQ-021 Wait counter plus timeout compare SHALL be the sub-module mc_wait_timer.

Verification
REQ-022 Reset, then lw (opcode 100011) with mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 only in state 4.
REQ-023 R-type with 2 FETCH wait cycles -> FETCH held 3 cycles; ir_write pulses once, in the third cycle; total 6 cycles.
REQ-024 beq and bne back-to-back -> state 8 with pc_write_cond=1, then state 9 with pc_write_cond_ne=1; pc_source=01 in both; 3 cycles each.
REQ-025 Opcode 111111 -> illegal_op=1 in DECODE, next state FETCH, no write strobe.
REQ-026 MAX_WAIT=3 with mem_ready=0 in MEMWR -> mem_timeout in the 4th wait cycle, then FETCH; with mem_ready=1 in that same cycle instead -> no timeout pulse.
REQ-027 MC_PERF_CNT_EN defined, 10 back-to-back addi with mem_ready=1 -> instr_cnt=10, cycle_cnt=40.
